// File: rtl/dpc_frame_ctrl.sv
// dpc_frame_ctrl: frame-level sequencer for the defective-pixel-correction
// pipeline. Tracks input/output pixel positions, shadows the DPC threshold and
// bypass at frame boundaries, flags border pixels of the 5x5 window and counts
// interior defects per frame.
// Optional feature: define DPC_FRAME_CTRL_TIMEOUT_EN to build the DRAIN
// watchdog; without it DRAIN waits indefinitely and err_timeout is tied low.
module dpc_frame_ctrl #(
    parameter int unsigned RAW_HPIXEL = 1936,
    parameter int unsigned RAW_VPIXEL = 1088,
    parameter int unsigned BORDER     = 2,
    parameter int unsigned CNT_W      = 21,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_enable,
    input  logic [7:0]       cfg_threshold,
    input  logic             cfg_bypass,
    input  logic             in_raw_data_en,
    input  logic             out_raw_data_en,
    input  logic             defect_flag,
    output logic [7:0]       dpc_threshold,
    output logic             dpc_bypass,
    output logic             border_flag,
    output logic             frame_busy,
    output logic             frame_start,
    output logic             frame_done,
    output logic [CNT_W-1:0] defect_cnt,
    output logic             err_overrun,
    output logic             err_timeout
);

    localparam int unsigned H_W   = (RAW_HPIXEL > 1) ? $clog2(RAW_HPIXEL) : 1;
    localparam int unsigned V_W   = (RAW_VPIXEL > 1) ? $clog2(RAW_VPIXEL) : 1;
    localparam int unsigned PIX_W = $clog2(RAW_HPIXEL * RAW_VPIXEL + 1);

    localparam logic [H_W-1:0]   H_LAST    = H_W'(RAW_HPIXEL - 1);
    localparam logic [V_W-1:0]   V_LAST    = V_W'(RAW_VPIXEL - 1);
    localparam logic [H_W-1:0]   H_LO      = H_W'(BORDER);
    localparam logic [H_W-1:0]   H_HI      = H_W'(RAW_HPIXEL - BORDER);
    localparam logic [V_W-1:0]   V_LO      = V_W'(BORDER);
    localparam logic [V_W-1:0]   V_HI      = V_W'(RAW_VPIXEL - BORDER);
    localparam logic [PIX_W-1:0] PIX_TOTAL = PIX_W'(RAW_HPIXEL * RAW_VPIXEL);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [H_W-1:0]     h_in_q, h_in_d;
    logic [V_W-1:0]     v_in_q, v_in_d;
    logic [H_W-1:0]     h_out_q, h_out_d;
    logic [V_W-1:0]     v_out_q, v_out_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   defect_cnt_q, defect_cnt_d;
    logic [7:0]         thr_q, thr_d;
    logic               byp_q, byp_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_busy_q, frame_busy_d;
    logic               err_overrun_q, err_overrun_d;

    logic               frame_active;
    logic               out_fire;
    logic               border_raw;

`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
    localparam int unsigned       WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_timeout_q, err_timeout_d;

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign frame_active = (state_q == RUN) || (state_q == DRAIN);
    assign out_fire     = out_raw_data_en && frame_active;

    // Border test on the current output position; gated by the strobe so the
    // flag reads 0 whenever no output pixel is present (including reset).
    assign border_raw  = (h_out_q < H_LO) || (h_out_q >= H_HI) ||
                         (v_out_q < V_LO) || (v_out_q >= V_HI);
    assign border_flag = border_raw && out_raw_data_en;

    assign dpc_threshold = thr_q;
    assign dpc_bypass    = byp_q;
    assign frame_busy    = frame_busy_q;
    assign frame_start   = frame_start_q;
    assign frame_done    = frame_done_q;
    assign defect_cnt    = defect_cnt_q;
    assign err_overrun   = err_overrun_q;

    // Next-state logic: FSM, pixel counters, shadow registers and error flags.
    always_comb begin
        state_d       = state_q;
        h_in_d        = h_in_q;
        v_in_d        = v_in_q;
        h_out_d       = h_out_q;
        v_out_d       = v_out_q;
        pix_cnt_d     = pix_cnt_q;
        acc_d         = acc_q;
        defect_cnt_d  = defect_cnt_q;
        thr_d         = thr_q;
        byp_d         = byp_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_overrun_d = err_overrun_q;
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
        wd_d          = wd_q;
        err_timeout_d = err_timeout_q;
`endif

        if (in_raw_data_en && (state_q != RUN)) begin
            err_overrun_d = 1'b1;
        end

        if (out_fire) begin
            if (h_out_q == H_LAST) begin
                h_out_d = '0;
                v_out_d = (v_out_q == V_LAST) ? '0 : v_out_q + 1'b1;
            end else begin
                h_out_d = h_out_q + 1'b1;
            end
            if (pix_cnt_q != PIX_TOTAL) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
            if (defect_flag && !border_raw && (acc_q != '1)) begin
                acc_d = acc_q + 1'b1;
            end
        end

`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
        // Idle-output count runs through RUN as well so that the abort lands
        // TIMEOUT cycles after the last output even if that output preceded
        // DRAIN; it saturates and only acts once in DRAIN.
        if (frame_active) begin
            if (out_raw_data_en) begin
                wd_d = '0;
            end else if (wd_q != WD_LAST) begin
                wd_d = wd_q + 1'b1;
            end
        end else begin
            wd_d = '0;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    state_d       = RUN;
                    thr_d         = cfg_threshold;
                    byp_d         = cfg_bypass;
                    frame_start_d = 1'b1;
                end
            end
            RUN: begin
                if (in_raw_data_en) begin
                    if (h_in_q == H_LAST) begin
                        h_in_d = '0;
                        if (v_in_q == V_LAST) begin
                            v_in_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            v_in_d = v_in_q + 1'b1;
                        end
                    end else begin
                        h_in_d = h_in_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pix_cnt_q == PIX_TOTAL) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
                else if (!out_raw_data_en && (wd_d == WD_LAST)) begin
                    state_d       = DONE;
                    frame_done_d  = 1'b1;
                    err_timeout_d = 1'b1;
                end
`endif
            end
            DONE: begin
                defect_cnt_d = acc_q;
                acc_d        = '0;
                h_out_d      = '0;
                v_out_d      = '0;
                pix_cnt_d    = '0;
                if (cfg_enable) begin
                    state_d       = RUN;
                    thr_d         = cfg_threshold;
                    byp_d         = cfg_bypass;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        frame_busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            h_in_q        <= '0;
            v_in_q        <= '0;
            h_out_q       <= '0;
            v_out_q       <= '0;
            pix_cnt_q     <= '0;
            acc_q         <= '0;
            defect_cnt_q  <= '0;
            thr_q         <= '0;
            byp_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_busy_q  <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            h_in_q        <= h_in_d;
            v_in_q        <= v_in_d;
            h_out_q       <= h_out_d;
            v_out_q       <= v_out_d;
            pix_cnt_q     <= pix_cnt_d;
            acc_q         <= acc_d;
            defect_cnt_q  <= defect_cnt_d;
            thr_q         <= thr_d;
            byp_q         <= byp_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_busy_q  <= frame_busy_d;
            err_overrun_q <= err_overrun_d;
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_dpc_frame_ctrl.sv
// tb_dpc_frame_ctrl: scoreboard bench for dpc_frame_ctrl with an 8x6 frame and
// the DPC pipeline modelled as a 6-cycle delay line carrying the defect bit.
module tb_dpc_frame_ctrl;

    localparam int H    = 8;
    localparam int V    = 6;
    localparam int B    = 2;
    localparam int T    = 16;
    localparam int CW   = 21;
    localparam int NPIX = H * V;
    localparam int DLY  = 6;

    typedef struct {
        int         cnt;
        int         bcnt;
        logic [7:0] thr;
        logic       byp;
        bit         to;
    } rec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [7:0]    cfg_threshold = '0;
    logic          cfg_bypass = 1'b0;
    logic          in_raw_data_en = 1'b0;
    logic          out_raw_data_en;
    logic          defect_flag;
    logic [7:0]    dpc_threshold;
    logic          dpc_bypass;
    logic          border_flag;
    logic          frame_busy;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] defect_cnt;
    logic          err_overrun;
    logic          err_timeout;

    dpc_frame_ctrl #(
        .RAW_HPIXEL(H),
        .RAW_VPIXEL(V),
        .BORDER(B),
        .CNT_W(CW),
        .TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_enable(cfg_enable),
        .cfg_threshold(cfg_threshold),
        .cfg_bypass(cfg_bypass),
        .in_raw_data_en(in_raw_data_en),
        .out_raw_data_en(out_raw_data_en),
        .defect_flag(defect_flag),
        .dpc_threshold(dpc_threshold),
        .dpc_bypass(dpc_bypass),
        .border_flag(border_flag),
        .frame_busy(frame_busy),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .defect_cnt(defect_cnt),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // DPC pipeline model: delayed strobe and defect decision, output gate.
    logic           feed = 1'b1;
    logic           pix_d = 1'b0;
    logic [DLY-1:0] dl_v = '0;
    logic [DLY-1:0] dl_d = '0;
    int             out_sent = 0;
    int             out_limit = 1000000;
    int             cyc = 0;

    always @(posedge clk) begin
        dl_v <= {dl_v[DLY-2:0], in_raw_data_en & feed};
        dl_d <= {dl_d[DLY-2:0], pix_d};
        cyc  <= cyc + 1;
        if (out_raw_data_en) out_sent <= out_sent + 1;
    end

    assign out_raw_data_en = dl_v[DLY-1] && (out_sent < out_limit);
    assign defect_flag     = dl_d[DLY-1];

    // Scoreboard state
    bit   bq[$];
    rec_t rq[$];
    bit   dfct[NPIX];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   chk_pend = 1'b0;
    int   pend_cnt = 0;
    int   border_hi = 0;
    int   last_out_cyc = 0;
    int   done_cnt = 0;
    rec_t mr;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin
        if (mon_en && rstn) begin
            if (chk_pend) begin
                check("defect_cnt", defect_cnt, pend_cnt);
                chk_pend = 1'b0;
            end
            if (out_raw_data_en) begin
                if (bq.size() == 0) flag_fail("border_no_expectation");
                else check("border_flag", border_flag, bq.pop_front());
                if (border_flag) border_hi++;
                last_out_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                if (rq.size() == 0) begin
                    flag_fail("frame_done_unexpected");
                end else begin
                    mr = rq.pop_front();
                    check("done_threshold", dpc_threshold, mr.thr);
                    check("done_bypass", dpc_bypass, mr.byp);
                    check("border_count", border_hi, mr.bcnt);
                    check("err_timeout_at_done", err_timeout, mr.to);
                    if (mr.to) check("timeout_latency", cyc - last_out_cyc, T);
                    pend_cnt = mr.cnt;
                    chk_pend = 1'b1;
                end
                border_hi = 0;
            end
        end
    end

    // Reference model: pixel p sits at (p % H, p / H); only the first n_out
    // pixels are delivered by the pipeline.
    task automatic gen_frame(input int n_out, input bit push_rec, input logic [7:0] thr,
                             input logic byp, input bit to);
        rec_t r;
        int   x;
        int   y;
        bit   brd;
        r.cnt = 0; r.bcnt = 0; r.thr = thr; r.byp = byp; r.to = to;
        for (int p = 0; p < NPIX; p++) begin
            dfct[p] = 1'($urandom_range(0, 1));
            x = p % H;
            y = p / H;
            brd = (x < B) || (x >= H - B) || (y < B) || (y >= V - B);
            if (p < n_out) begin
                bq.push_back(brd);
                if (brd) r.bcnt++;
                else if (dfct[p]) r.cnt++;
            end
        end
        if (push_rec) rq.push_back(r);
    endtask

    task automatic send_pixel(input int p, input bit nogap);
        int gap;
        gap = nogap ? 0 : int'($urandom_range(0, 2));
        repeat (gap) begin
            in_raw_data_en = 1'b0;
            pix_d = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_raw_data_en = 1'b1;
        pix_d = dfct[p];
        @(negedge clk);
        in_raw_data_en = 1'b0;
        pix_d = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int n, input bit nogap, input int drop_at);
        for (int p = 0; p < n; p++) begin
            if (p == drop_at) cfg_enable = 1'b0;
            send_pixel(p, nogap);
        end
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag_fail("frame_start_timeout");
    endtask

    task automatic wait_done_cnt(input int target);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag_fail("frame_done_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_threshold"}, dpc_threshold, 0);
        check({tag, "_bypass"}, dpc_bypass, 0);
        check({tag, "_busy"}, frame_busy, 0);
        check({tag, "_start"}, frame_start, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_defect_cnt"}, defect_cnt, 0);
        check({tag, "_err_overrun"}, err_overrun, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_border"}, border_flag, 0);
    endtask

    initial begin
        int base;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Shadow timing: threshold changes mid-frame must not reach the DPC
        cfg_threshold = 8'd40;
        cfg_bypass    = 1'b0;
        cfg_enable    = 1'b1;
        gen_frame(NPIX, 1'b1, 8'd40, 1'b0, 1'b0);
        wait_start();
        for (int p = 0; p < NPIX; p++) begin
            if (p == 20) begin
                cfg_threshold = 8'd90;
                cfg_bypass    = 1'b1;
            end
            if (p == 30) begin
                check("shadow_thr_mid", dpc_threshold, 40);
                check("shadow_byp_mid", dpc_bypass, 0);
                check("busy_in_run", frame_busy, 1);
            end
            send_pixel(p, 1'b0);
        end

        // Back-to-back second frame loads the new settings
        gen_frame(NPIX, 1'b1, 8'd90, 1'b1, 1'b0);
        wait_start();
        check("shadow_thr_reload", dpc_threshold, 90);
        check("shadow_byp_reload", dpc_bypass, 1);
        send_frame(NPIX, 1'b0, -1);

        // Third frame: enable dropped during RUN, frame still completes
        gen_frame(NPIX, 1'b1, 8'd90, 1'b1, 1'b0);
        wait_start();
        send_frame(NPIX, 1'b0, 10);
        wait_done_cnt(3);
        repeat (3) @(negedge clk);
        check("three_frames_done", done_cnt, 3);
        check("idle_after_stop", frame_busy, 0);
        repeat (20) @(negedge clk);
        check("no_restart_when_disabled", done_cnt, 3);
        check("err_overrun_clean", err_overrun, 0);

        // Overrun: one stray input strobe during DRAIN
        cfg_threshold = 8'd55;
        cfg_bypass    = 1'b0;
        cfg_enable    = 1'b1;
        gen_frame(NPIX, 1'b1, 8'd55, 1'b0, 1'b0);
        wait_start();
        send_frame(NPIX, 1'b0, 5);
        @(negedge clk);
        check("overrun_before", err_overrun, 0);
        feed = 1'b0;
        in_raw_data_en = 1'b1;
        @(negedge clk);
        in_raw_data_en = 1'b0;
        feed = 1'b1;
        check("overrun_set", err_overrun, 1);
        wait_done_cnt(4);
        repeat (5) @(negedge clk);
        check("overrun_sticky", err_overrun, 1);
        check("idle_after_overrun", frame_busy, 0);

        // Timeout: outputs stop after 30 pixels
        cfg_threshold = 8'd66;
        cfg_enable    = 1'b1;
        out_limit     = out_sent + 30;
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
        gen_frame(30, 1'b1, 8'd66, 1'b0, 1'b1);
`else
        gen_frame(30, 1'b0, 8'd66, 1'b0, 1'b0);
`endif
        wait_start();
        send_frame(NPIX, 1'b1, 3);
`ifdef DPC_FRAME_CTRL_TIMEOUT_EN
        wait_done_cnt(5);
        repeat (3) @(negedge clk);
        check("timeout_flag", err_timeout, 1);
        check("idle_after_timeout", frame_busy, 0);
`else
        repeat (40) @(negedge clk);
        check("stuck_in_drain_busy", frame_busy, 1);
        check("no_timeout_flag", err_timeout, 0);
        check("no_done_without_outputs", done_cnt, 4);
`endif
        out_limit = 1000000;

        // Reset mid-RUN at input pixel 20, then a clean frame
        mon_en = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        cfg_threshold = 8'd12;
        cfg_enable    = 1'b1;
        gen_frame(0, 1'b0, 8'd12, 1'b0, 1'b0);
        wait_start();
        send_frame(20, 1'b0, -1);
        rstn = 1'b0;
        cfg_enable = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        bq.delete();
        rq.delete();
        chk_pend  = 1'b0;
        border_hi = 0;
        mon_en    = 1'b1;

        base = done_cnt;
        cfg_threshold = 8'd77;
        cfg_bypass    = 1'b1;
        cfg_enable    = 1'b1;
        gen_frame(NPIX, 1'b1, 8'd77, 1'b1, 1'b0);
        wait_start();
        send_frame(NPIX, 1'b0, 2);
        wait_done_cnt(base + 1);
        repeat (3) @(negedge clk);
        check("post_reset_idle", frame_busy, 0);
        check("post_reset_thr_held", dpc_threshold, 77);
        check("post_reset_overrun_clear", err_overrun, 0);
        check("scoreboard_drained", bq.size() + rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", fails);
        $fatal(1, "global timeout");
    end

endmodule
